// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus slice seen by the memory-mapped UART transmitter.
interface mmio_uart_tx_if;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] data_out;
    logic        sel;

    modport master (
        output address, data_in, write_enable, read_enable,
        input  data_out, sel
    );

    modport slave (
        input  address, data_in, write_enable, read_enable,
        output data_out, sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, circular TX FIFO
// and a start/data/stop serialiser that chains frames without idle gaps.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         reset,
    mmio_uart_tx_if.slave bus,
    output logic         tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    state_t          state_r, state_next_s;
    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;
    logic [BW-1:0]   bit_cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            tx_r, tx_next_s, pop_s;
    logic            sel_s, wr_data_s, wr_status_s, rd_status_s;
    logic            full_s, empty_s, busy_s, bit_done_s, push_s, drop_s;
    logic [7:0]      count_byte_s;
    logic [31:0]     status_s;
    logic            unused_s;

    assign sel_s       = (bus.address[31:3] == BASE_ADDR[31:3]);
    assign wr_data_s   = bus.write_enable && sel_s && (bus.address[2:0] == 3'd0);
    assign wr_status_s = bus.write_enable && sel_s && (bus.address[2:0] == 3'd4);
    assign rd_status_s = bus.read_enable  && sel_s && (bus.address[2:0] == 3'd4);
    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == {CW{1'b0}});
    assign busy_s      = (state_r != IDLE);
    assign bit_done_s  = (bit_cnt_r == BIT_LAST);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_s      = wr_data_s && (!full_s || pop_s);
    assign drop_s      = wr_data_s && full_s && !pop_s;
    assign count_byte_s = 8'(count_r);
    assign status_s    = {16'h0000, count_byte_s, 4'h0, overflow_r, busy_s, empty_s, full_s};
    assign bus.data_out = rd_status_s ? status_s : 32'h0000_0000;
    assign bus.sel      = sel_s;
    assign tx           = tx_r;
    assign unused_s     = ^{bus.data_in[31:8]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = empty_s ? IDLE : START;
            START:   state_next_s = bit_done_s ? DATA : START;
            DATA:    state_next_s = (bit_done_s && (bit_idx_r == 3'd7)) ? STOP : DATA;
            STOP:    state_next_s = !bit_done_s ? STOP : (empty_s ? IDLE : START);
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: FIFO pop strobe and the value tx takes at the next edge
    always_comb begin
        pop_s     = 1'b0;
        tx_next_s = 1'b1;
        case (state_r)
            IDLE: begin
                pop_s     = !empty_s;
                tx_next_s = empty_s;
            end
            START: begin
                tx_next_s = bit_done_s ? shift_r[0] : 1'b0;
            end
            DATA: begin
                if (!bit_done_s) begin
                    tx_next_s = shift_r[0];
                end else begin
                    tx_next_s = (bit_idx_r == 3'd7) ? 1'b1 : shift_r[1];
                end
            end
            STOP: begin
                pop_s     = bit_done_s && !empty_s;
                tx_next_s = !(bit_done_s && !empty_s);
            end
            default: begin
                pop_s     = 1'b0;
                tx_next_s = 1'b1;
            end
        endcase
    end

    // Serialiser datapath: bit timer, bit index, shift register, registered tx
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_r      <= 1'b1;
            bit_cnt_r <= {BW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            tx_r      <= tx_next_s;
            bit_cnt_r <= ((state_r == IDLE) || bit_done_s) ? {BW{1'b0}} : bit_cnt_r + BIT_ONE;
            if (pop_s) begin
                shift_r <= mem_r[rd_ptr_r];
            end else if ((state_r == DATA) && bit_done_s) begin
                shift_r <= {1'b0, shift_r[7:1]};
            end
            if (state_r == START) begin
                bit_idx_r <= 3'd0;
            end else if ((state_r == DATA) && bit_done_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
        end
    end

    // FIFO storage; stale entries need no reset because the pointers are cleared
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            mem_r[wr_ptr_r] <= bus.data_in[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (wr_status_s && bus.data_in[3]) begin
                overflow_r <= 1'b0;
            end
        end
    end
endmodule
